pixel_scan_controller: RTL and testbench

Upstream stage of sequencer_for_PIX_V1_SW_28_10_19. It steps the pixel select code over a programmed range and fires a fixed number of sequencer runs per pixel. Each run is a one-cycle `run_sequencer` pulse, handshaken against the sequencer's `ready_flag`. It also counts `measure_flag` windows, and reports busy, done and timeout status to the host register interface.

---
 rtl/pix_scan_pkg.sv | 23 ++
 rtl/pixel_scan_controller_cycle_timer.sv | 27 ++
 rtl/pixel_scan_controller.sv | 210 +++++++++++++++++++++
 tb/tb_pixel_scan_controller.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pix_scan_pkg.sv
// Shared definitions for the pixel scan controller: FSM state encoding,
// parameter defaults and a timer width helper.
package pix_scan_pkg;

    localparam int SEL_WIDTH_DEFAULT      = 4;
    localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_FIRE,
        ST_WAIT_ACCEPT,
        ST_WAIT_DONE,
        ST_GAP,
        ST_NEXT
    } scan_state_t;

    // Bits needed to hold the values 0 .. cycles-1 (never less than one).
    function automatic int timer_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/pixel_scan_controller_cycle_timer.sv
// Loadable down-counter that parks at zero; zero flag follows the register.
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && (count_reg != '0)) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/pixel_scan_controller.sv
// Steps the pixel select code over a programmed range, firing a fixed number
// of handshaken sequencer runs per pixel, with gap, watchdog and status.
module pixel_scan_controller
    import pix_scan_pkg::*;
#(
    parameter int SEL_WIDTH      = SEL_WIDTH_DEFAULT,
    parameter int COUNT_WIDTH    = 16,
    parameter int GAP_WIDTH      = 10,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [SEL_WIDTH-1:0]   sel_first,
    input  logic [SEL_WIDTH-1:0]   sel_last,
    input  logic [COUNT_WIDTH-1:0] runs_per_pixel,
    input  logic [GAP_WIDTH-1:0]   gap_time,
    input  logic                   ready_flag,
    input  logic                   measure_flag,
    output logic                   run_sequencer,
    output logic [SEL_WIDTH-1:0]   SEL_input,
    output logic                   busy,
    output logic                   done,
    output logic                   error_flag,
    output logic [COUNT_WIDTH-1:0] run_count,
    output logic [COUNT_WIDTH-1:0] measure_count
);

    localparam int                  WD_WIDTH  = timer_width(TIMEOUT_CYCLES);
    localparam logic [WD_WIDTH-1:0] WD_RELOAD = WD_WIDTH'(TIMEOUT_CYCLES - 1);

    scan_state_t            state_reg;
    logic [SEL_WIDTH-1:0]   sel_reg;
    logic [SEL_WIDTH-1:0]   sel_last_reg;
    logic [COUNT_WIDTH-1:0] runs_reg;
    logic [COUNT_WIDTH-1:0] run_idx_reg;
    logic [COUNT_WIDTH-1:0] run_count_reg;
    logic [COUNT_WIDTH-1:0] measure_count_reg;
    logic [GAP_WIDTH-1:0]   gap_reg;
    logic                   run_sequencer_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   error_reg;
    logic                   measure_prev_reg;

    logic                   wd_load;
    logic                   wd_zero;
    logic                   gap_load;
    logic                   gap_zero;
    logic [GAP_WIDTH-1:0]   gap_reload;

    // The watchdog is reloaded on the cycle before every entry into a watched
    // state; reloading it in other states is harmless since it is ignored there.
    always_comb begin
        wd_load = 1'b0;
        case (state_reg)
            ST_IDLE, ST_FIRE, ST_NEXT: wd_load = 1'b1;
            ST_WAIT_ACCEPT:            wd_load = !ready_flag;
            default:                   wd_load = 1'b0;
        endcase
    end

    // Loading gap_time-1 makes GAP last exactly gap_time cycles.
    assign gap_load   = (state_reg != ST_GAP);
    assign gap_reload = gap_reg - GAP_WIDTH'(1);

    cycle_timer #(
        .WIDTH(WD_WIDTH)
    ) u_watchdog (
        .clk       (clk),
        .srst      (reset),
        .load      (wd_load),
        .load_value(WD_RELOAD),
        .enable    (1'b1),
        .zero      (wd_zero)
    );

    cycle_timer #(
        .WIDTH(GAP_WIDTH)
    ) u_gap_timer (
        .clk       (clk),
        .srst      (reset),
        .load      (gap_load),
        .load_value(gap_reload),
        .enable    (state_reg == ST_GAP),
        .zero      (gap_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            sel_reg           <= '0;
            sel_last_reg      <= '0;
            runs_reg          <= '0;
            run_idx_reg       <= '0;
            run_count_reg     <= '0;
            measure_count_reg <= '0;
            gap_reg           <= '0;
            run_sequencer_reg <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            error_reg         <= 1'b0;
            measure_prev_reg  <= 1'b0;
        end else begin
            run_sequencer_reg <= 1'b0;
            done_reg          <= 1'b0;
            measure_prev_reg  <= measure_flag;

            if (busy_reg && measure_flag && !measure_prev_reg && (measure_count_reg != '1)) begin
                measure_count_reg <= measure_count_reg + COUNT_WIDTH'(1);
            end

            if (abort && (state_reg != ST_IDLE)) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            sel_reg           <= sel_first;
                            sel_last_reg      <= sel_last;
                            runs_reg          <= runs_per_pixel;
                            gap_reg           <= gap_time;
                            run_idx_reg       <= '0;
                            run_count_reg     <= '0;
                            measure_count_reg <= '0;
                            error_reg         <= 1'b0;
                            if (sel_last < sel_first) begin
                                error_reg <= 1'b1;
                                done_reg  <= 1'b1;
                            end else if (runs_per_pixel == '0) begin
                                done_reg <= 1'b1;
                            end else begin
                                state_reg <= ST_ARM;
                                busy_reg  <= 1'b1;
                            end
                        end
                    end
                    ST_ARM: begin
                        if (ready_flag) begin
                            state_reg         <= ST_FIRE;
                            run_sequencer_reg <= 1'b1;
                        end else if (wd_zero) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                            error_reg <= 1'b1;
                        end
                    end
                    ST_FIRE: begin
                        state_reg <= ST_WAIT_ACCEPT;
                    end
                    ST_WAIT_ACCEPT: begin
                        if (!ready_flag) begin
                            state_reg <= ST_WAIT_DONE;
                        end else if (wd_zero) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                            error_reg <= 1'b1;
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (ready_flag) begin
                            if (run_count_reg != '1) begin
                                run_count_reg <= run_count_reg + COUNT_WIDTH'(1);
                            end
                            state_reg <= (gap_reg == '0) ? ST_NEXT : ST_GAP;
                        end else if (wd_zero) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                            error_reg <= 1'b1;
                        end
                    end
                    ST_GAP: begin
                        if (gap_zero) begin
                            state_reg <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        if ((run_idx_reg + COUNT_WIDTH'(1)) < runs_reg) begin
                            run_idx_reg <= run_idx_reg + COUNT_WIDTH'(1);
                            state_reg   <= ST_ARM;
                        end else if (sel_reg == sel_last_reg) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            sel_reg     <= sel_reg + SEL_WIDTH'(1);
                            run_idx_reg <= '0;
                            state_reg   <= ST_ARM;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign run_sequencer = run_sequencer_reg;
    assign SEL_input     = sel_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign error_flag    = error_reg;
    assign run_count     = run_count_reg;
    assign measure_count = measure_count_reg;

endmodule

// File: tb/tb_pixel_scan_controller.sv
// Directed bench for pixel_scan_controller: a sequencer model drives the
// handshake, a fire-order scoreboard and an every-cycle monitor check the DUT.
module tb_pixel_scan_controller;

    localparam int SW = 4;
    localparam int CW = 16;
    localparam int GW = 10;
    localparam int TO = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] sel_first = '0;
    logic [SW-1:0] sel_last = '0;
    logic [CW-1:0] runs_per_pixel = '0;
    logic [GW-1:0] gap_time = '0;
    logic          ready_flag;
    logic          measure_flag;
    logic          run_sequencer;
    logic [SW-1:0] SEL_input;
    logic          busy;
    logic          done;
    logic          error_flag;
    logic [CW-1:0] run_count;
    logic [CW-1:0] measure_count;

    always #5 clk = ~clk;

    pixel_scan_controller #(
        .SEL_WIDTH(SW), .COUNT_WIDTH(CW), .GAP_WIDTH(GW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .sel_first(sel_first), .sel_last(sel_last),
        .runs_per_pixel(runs_per_pixel), .gap_time(gap_time),
        .ready_flag(ready_flag), .measure_flag(measure_flag),
        .run_sequencer(run_sequencer), .SEL_input(SEL_input),
        .busy(busy), .done(done), .error_flag(error_flag),
        .run_count(run_count), .measure_count(measure_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scenario knobs read by the sequencer model and the monitor.
    int run_len          = 4;
    bit stuck            = 1'b0;
    bit meas_en          = 1'b0;
    bit exp_done_on_fall = 1'b1;
    int exp_spacing      = 0;

    int exp_sel[$];
    int fires = 0;
    int dones = 0;
    int cycle = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected fire order: every pixel in range, runs_per_pixel times each.
    task automatic push_model(input int first, input int last, input int runs);
        for (int s = first; s <= last; s++) begin
            for (int r = 0; r < runs; r++) exp_sel.push_back(s);
        end
    endtask

    // Sequencer: ready drops for run_len cycles after each fire; optional one-cycle measure window.
    initial begin : sequencer_model
        int cnt;
        cnt          = 0;
        ready_flag   = 1'b1;
        measure_flag = 1'b0;
        forever begin
            @(negedge clk);
            if (run_sequencer === 1'b1) begin
                ready_flag   = 1'b0;
                cnt          = run_len;
                measure_flag = meas_en;
            end else begin
                measure_flag = 1'b0;
                if (cnt > 0) cnt--;
                if (cnt == 0 && !stuck) ready_flag = 1'b1;
            end
        end
    end

    initial begin : monitor
        bit prev_busy;
        bit prev_fire;
        bit prev_done;
        int last_fire;
        prev_busy = 1'b0;
        prev_fire = 1'b0;
        prev_done = 1'b0;
        last_fire = -1;
        forever begin
            @(negedge clk);
            cycle++;
            if (busy !== 1'b1) last_fire = -1;
            if (run_sequencer === 1'b1) begin
                fires++;
                $display("fire %0d: sel=%0d run_count=%0d t=%0t", fires, SEL_input, run_count, $time);
                check("fire_one_cycle", prev_fire, 0);
                check("fire_expected", exp_sel.size() > 0, 1);
                if (exp_sel.size() > 0) check("fire_sel", SEL_input, exp_sel.pop_front());
                if (last_fire >= 0) check("fire_spacing", cycle - last_fire, exp_spacing);
                last_fire = cycle;
            end
            if (done === 1'b1) begin
                dones++;
                $display("done: run_count=%0d measure_count=%0d error=%0d t=%0t",
                         run_count, measure_count, error_flag, $time);
                check("done_one_cycle", prev_done, 0);
                check("done_not_busy", busy, 0);
            end
            if (prev_busy && busy === 1'b0) check("done_at_busy_fall", done, exp_done_on_fall);
            prev_busy = (busy === 1'b1);
            prev_fire = (run_sequencer === 1'b1);
            prev_done = (done === 1'b1);
        end
    end

    task automatic start_scan(input int f, input int l, input int r, input int g);
        sel_first      = SW'(f);
        sel_last       = SW'(l);
        runs_per_pixel = CW'(r);
        gap_time       = GW'(g);
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_fire(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (run_sequencer !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("fire_within_budget", run_sequencer, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", busy, 0);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_run_sequencer"}, run_sequencer, 0);
        check({tag, "_sel"}, SEL_input, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error_flag, 0);
        check({tag, "_run_count"}, run_count, 0);
        check({tag, "_measure_count"}, measure_count, 0);
    endtask

    initial begin : global_guard
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, t=%0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int f0;
        int d0;
        int k;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Range 3..5, two runs each, gap 4: six fires spaced 4+4+3 apart.
        run_len = 4; exp_spacing = 11; exp_done_on_fall = 1'b1;
        f0 = fires; d0 = dones;
        push_model(3, 5, 2);
        start_scan(3, 5, 2, 4);
        check("t1_busy_first_cycle", busy, 1);
        check("t1_no_fire_first_cycle", run_sequencer, 0);
        @(negedge clk);
        check("t1_fire_second_cycle", run_sequencer, 1);
        wait_idle(1000);
        check("t1_fires", fires - f0, 6);
        check("t1_run_count", run_count, 6);
        check("t1_dones", dones - d0, 1);
        check("t1_error", error_flag, 0);
        check("t1_queue_drained", exp_sel.size(), 0);

        // Bad range: immediate done with error, no fire.
        f0 = fires; d0 = dones;
        start_scan(7, 2, 1, 0);
        check("t2_done", done, 1);
        check("t2_error", error_flag, 1);
        check("t2_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("t2_fires", fires - f0, 0);
        check("t2_dones", dones - d0, 1);

        // Zero runs per pixel: done without error, no fire.
        f0 = fires; d0 = dones;
        start_scan(1, 2, 0, 0);
        check("t2b_done", done, 1);
        check("t2b_error_cleared", error_flag, 0);
        repeat (5) @(negedge clk);
        check("t2b_fires", fires - f0, 0);
        check("t2b_dones", dones - d0, 1);

        // Stuck sequencer: one fire, then timeout after FIRE + WAIT_ACCEPT + TO cycles.
        run_len = 3; stuck = 1'b1; exp_done_on_fall = 1'b0;
        d0 = dones;
        push_model(1, 1, 1);
        start_scan(1, 1, 1, 0);
        wait_fire(10);
        k = 0;
        while (busy === 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("t3_timeout_cycles", k, TO + 2);
        check("t3_error", error_flag, 1);
        check("t3_busy", busy, 0);
        @(negedge clk);
        check("t3_no_done", dones - d0, 0);
        check("t3_run_count", run_count, 0);
        stuck = 1'b0;
        repeat (3) @(negedge clk);

        // Abort inside the GAP after run 2, then a clean restart at sel_first.
        run_len = 3; exp_spacing = 12; exp_done_on_fall = 1'b1;
        d0 = dones;
        push_model(2, 3, 2);
        start_scan(2, 3, 2, 6);
        wait_fire(10);
        wait_fire(40);
        repeat (5) @(negedge clk);
        exp_done_on_fall = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_abort_busy", busy, 0);
        check("t4_abort_done", done, 0);
        check("t4_abort_fire", run_sequencer, 0);
        check("t4_abort_run_count_held", run_count, 2);
        exp_sel.delete();
        repeat (3) @(negedge clk);
        exp_done_on_fall = 1'b1;
        push_model(2, 3, 2);
        start_scan(2, 3, 2, 6);
        wait_fire(10);
        check("t4_restart_sel", SEL_input, 2);
        wait_idle(1000);
        check("t4_restart_run_count", run_count, 4);
        check("t4_dones", dones - d0, 1);
        check("t4_queue_drained", exp_sel.size(), 0);

        // Reset while waiting for the sequencer to finish.
        run_len = 6; exp_done_on_fall = 1'b0;
        push_model(0, 1, 1);
        start_scan(0, 1, 1, 0);
        wait_fire(10);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("t5_reset");
        exp_sel.delete();
        repeat (10) @(negedge clk);

        // Back-to-back runs with measure windows; a start mid-scan is ignored.
        run_len = 5; exp_spacing = 8; meas_en = 1'b1; exp_done_on_fall = 1'b1;
        f0 = fires; d0 = dones;
        push_model(9, 9, 3);
        start_scan(9, 9, 3, 0);
        wait_fire(10);
        sel_first = SW'(0); sel_last = SW'(15); runs_per_pixel = CW'(7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(1000);
        check("t6_measure_count", measure_count, 3);
        check("t6_run_count", run_count, 3);
        check("t6_fires", fires - f0, 3);
        check("t6_dones", dones - d0, 1);
        check("t6_error", error_flag, 0);
        check("t6_queue_drained", exp_sel.size(), 0);
        meas_en = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_idle_after", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
